// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the memory buffer register FSM state type.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 8;
  // Instruction word layout: opcode in the upper byte, address field in the lower byte.
  localparam int OPC_MSB = CPU_DATA_W - 1;
  localparam int OPC_LSB = 8;
  localparam int ADR_MSB = 7;
  localparam int ADR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mbr_state_t;
endpackage

// File: rtl/mem_handshake_fsm.sv
// RAM req/ack handshake for the MBR: owns state, ack timeout counter and done/err flags.
module mem_handshake_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rd,
  input  logic i_wr,
  input  logic i_ack,
  output logic o_req,
  output logic o_we,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  output logic o_rd_load
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mbr_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             done_d, err_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      o_done <= done_d;
      o_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    err_d   = o_err;
    case (state)
      IDLE: begin
        cnt_d = '0;
        // Read wins a same-cycle rd/wr; an accepted transfer clears a stale timeout.
        if (i_rd) begin
          state_d = RD_WAIT;
          err_d   = 1'b0;
        end else if (i_wr) begin
          state_d = WR_WAIT;
          err_d   = 1'b0;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (i_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req     = (state != IDLE);
    o_we      = (state == WR_WAIT);
    o_busy    = (state != IDLE);
    o_rd_load = (state == RD_WAIT) && i_ack;
  end
endmodule

// File: rtl/mbr_unit.sv
// Memory buffer register: single data buffer between RAM and PC/IR/BR/ACC.
module mbr_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc_mbr,
  input  logic [DATA_W-1:0] i_acc_mbr,
  input  logic              i_ctl_pc_in,
  input  logic              i_ctl_acc_in,
  input  logic              i_ctl_rd,
  input  logic              i_ctl_wr,
  input  logic              i_ctl_to_pc,
  input  logic              i_ctl_to_ir,
  input  logic              i_ctl_to_br,
  output logic [ADDR_W-1:0] o_mbr_pc,
  output logic [DATA_W-1:0] o_mbr_ir,
  output logic [DATA_W-1:0] o_mbr_br,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  logic [DATA_W-1:0] mbr_q;
  logic              rd_load;

  mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd      (i_ctl_rd),
    .i_wr      (i_ctl_wr),
    .i_ack     (i_mem_ack),
    .o_req     (o_mem_req),
    .o_we      (o_mem_we),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_rd_load (rd_load)
  );

  // Captures only land while idle so write data stays frozen for the whole transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            mbr_q <= '0;
    else if (rd_load)        mbr_q <= i_mem_rdata;
    else if (!o_busy) begin
      if (i_ctl_acc_in)      mbr_q <= i_acc_mbr;
      else if (i_ctl_pc_in)  mbr_q <= DATA_W'(i_pc_mbr);
    end
  end

  // PC loads on any nonzero value, so the address field must read 0 when not selected.
  assign o_mbr_pc    = i_ctl_to_pc ? mbr_q[ADDR_W-1:0] : '0;
  assign o_mbr_ir    = i_ctl_to_ir ? mbr_q : '0;
  assign o_mbr_br    = i_ctl_to_br ? mbr_q : '0;
  assign o_mem_wdata = mbr_q;
endmodule

// File: tb/tb_mbr_unit.sv
// Self-checking bench for mbr_unit: gating vectors, directed transfers, random vs. model.
module tb_mbr_unit;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pc_mbr = '0;
  logic [15:0] i_acc_mbr = '0;
  logic        i_ctl_pc_in = 0, i_ctl_acc_in = 0, i_ctl_rd = 0, i_ctl_wr = 0;
  logic        i_ctl_to_pc = 0, i_ctl_to_ir = 0, i_ctl_to_br = 0;
  logic [7:0]  o_mbr_pc;
  logic [15:0] o_mbr_ir, o_mbr_br, o_mem_wdata;
  logic        o_mem_req, o_mem_we, o_busy, o_done, o_err;
  logic        i_mem_ack = 0;
  logic [15:0] i_mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  mbr_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_mbr(i_pc_mbr), .i_acc_mbr(i_acc_mbr),
    .i_ctl_pc_in(i_ctl_pc_in), .i_ctl_acc_in(i_ctl_acc_in), .i_ctl_rd(i_ctl_rd),
    .i_ctl_wr(i_ctl_wr), .i_ctl_to_pc(i_ctl_to_pc), .i_ctl_to_ir(i_ctl_to_ir),
    .i_ctl_to_br(i_ctl_to_br), .o_mbr_pc(o_mbr_pc), .o_mbr_ir(o_mbr_ir),
    .o_mbr_br(o_mbr_br), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clr_in();
    i_ctl_pc_in = 0; i_ctl_acc_in = 0; i_ctl_rd = 0; i_ctl_wr = 0;
    i_ctl_to_pc = 0; i_ctl_to_ir = 0; i_ctl_to_br = 0;
    i_mem_ack = 0; i_pc_mbr = '0;
  endtask

  typedef struct {
    logic        pc_in;
    logic [7:0]  pc;
    logic        acc_in;
    logic [15:0] acc;
    logic        to_pc, to_ir, to_br;
    logic [7:0]  e_pc;
    logic [15:0] e_ir, e_br;
  } vec_t;
  vec_t vecs[6];

  // Reference model state, kept as plain transaction bookkeeping.
  logic [15:0] m_buf;
  int          m_mode;   // 0 idle, 1 read pending, 2 write pending
  int          m_waits;
  bit          m_done, m_err;

  initial begin
    vecs[0] = '{0, 8'h00, 1, 16'h3C2F, 1, 0, 0, 8'h2F, 16'h0000, 16'h0000};
    vecs[1] = '{0, 8'h00, 1, 16'h3C2F, 0, 1, 0, 8'h00, 16'h3C2F, 16'h0000};
    vecs[2] = '{1, 8'h07, 1, 16'h1234, 0, 0, 1, 8'h00, 16'h0000, 16'h1234};
    vecs[3] = '{1, 8'h07, 0, 16'h9999, 0, 1, 1, 8'h00, 16'h0007, 16'h0007};
    vecs[4] = '{1, 8'h80, 0, 16'h0000, 1, 0, 0, 8'h80, 16'h0000, 16'h0000};
    vecs[5] = '{0, 8'h00, 1, 16'hFFFF, 1, 1, 1, 8'hFF, 16'hFFFF, 16'hFFFF};

    // Reset state
    #3;
    chk("rst_req", o_mem_req, 0); chk("rst_we", o_mem_we, 0);
    chk("rst_busy", o_busy, 0);   chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    i_ctl_to_ir = 1; #1; chk("rst_buf", o_mbr_ir, 16'h0000); i_ctl_to_ir = 0;
    tick(); i_rst_n = 1; tick();

    // Capture and output gating vectors
    foreach (vecs[i]) begin
      i_ctl_pc_in = vecs[i].pc_in; i_pc_mbr = vecs[i].pc;
      i_ctl_acc_in = vecs[i].acc_in; i_acc_mbr = vecs[i].acc;
      tick();
      clr_in();
      i_ctl_to_pc = vecs[i].to_pc; i_ctl_to_ir = vecs[i].to_ir; i_ctl_to_br = vecs[i].to_br;
      #1;
      chk($sformatf("vec%0d_pc", i), o_mbr_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_ir", i), o_mbr_ir, vecs[i].e_ir);
      chk($sformatf("vec%0d_br", i), o_mbr_br, vecs[i].e_br);
      clr_in();
    end
    // Jump gating drops in the same cycle
    i_ctl_acc_in = 1; i_acc_mbr = 16'h3C2F; tick(); clr_in();
    i_ctl_to_pc = 1; #1; chk("jump_on", o_mbr_pc, 8'h2F);
    i_ctl_to_pc = 0; #1; chk("jump_off", o_mbr_pc, 8'h00);

    // Read: ack in third wait cycle
    tick(); i_ctl_rd = 1; tick(); i_ctl_rd = 0; #1;
    chk("rd_req", {o_mem_req, o_mem_we, o_busy}, 3'b101);
    tick(); tick();
    i_mem_ack = 1; i_mem_rdata = 16'h1A05; #1;
    chk("rd_nodone_yet", o_done, 0);
    tick(); i_mem_ack = 0; #1;
    chk("rd_done", o_done, 1); chk("rd_idle", {o_mem_req, o_busy}, 2'b00);
    i_ctl_to_ir = 1; #1;
    chk("rd_ir", o_mbr_ir, 16'h1A05); chk("rd_pc_gated", o_mbr_pc, 8'h00);
    tick(); clr_in(); #1; chk("rd_done_pulse", o_done, 0);

    // Write with capture attempt mid-wait
    i_ctl_acc_in = 1; i_acc_mbr = 16'hBEEF; tick(); clr_in();
    i_ctl_wr = 1; tick(); i_ctl_wr = 0; #1;
    chk("wr_req", {o_mem_req, o_mem_we}, 2'b11); chk("wr_wdata", o_mem_wdata, 16'hBEEF);
    i_ctl_acc_in = 1; i_acc_mbr = 16'h0000; tick(); clr_in();
    i_mem_ack = 1; #1;
    chk("wr_we_held", {o_mem_req, o_mem_we}, 2'b11); chk("wr_frozen", o_mem_wdata, 16'hBEEF);
    tick(); i_mem_ack = 0; #1;
    chk("wr_done", o_done, 1);
    i_ctl_to_br = 1; #1; chk("wr_buf", o_mbr_br, 16'hBEEF);
    tick(); clr_in();

    // Timeout
    i_ctl_rd = 1; tick(); i_ctl_rd = 0;
    for (int k = 0; k < 15; k++) begin
      #1; chk($sformatf("to_req%0d", k), o_mem_req, 1);
      tick();
    end
    #1;
    chk("to_dropped", {o_mem_req, o_busy, o_done}, 3'b000); chk("to_err", o_err, 1);
    i_ctl_to_ir = 1; #1; chk("to_buf_kept", o_mbr_ir, 16'hBEEF);
    tick(); clr_in(); #1;
    chk("to_err_sticky", {o_err, o_done}, 2'b10);
    i_ctl_rd = 1; tick(); i_ctl_rd = 0; #1;
    chk("to_err_clr", {o_err, o_busy}, 2'b01);
    i_mem_ack = 1; i_mem_rdata = 16'h0101; tick(); i_mem_ack = 0; #1;
    chk("to_recover_done", o_done, 1);

    // rd + wr same cycle: read wins
    tick(); i_ctl_rd = 1; i_ctl_wr = 1; tick(); clr_in(); #1;
    chk("both_read", {o_mem_req, o_mem_we}, 2'b10);
    i_mem_ack = 1; i_mem_rdata = 16'h5555; tick(); i_mem_ack = 0;
    i_ctl_to_ir = 1; #1; chk("both_rdata", o_mbr_ir, 16'h5555);
    tick(); clr_in();

    // Reset in the middle of a write
    i_ctl_acc_in = 1; i_acc_mbr = 16'hA5A5; tick(); clr_in();
    i_ctl_wr = 1; tick(); i_ctl_wr = 0; #1;
    chk("rstw_req", {o_mem_req, o_mem_we}, 2'b11);
    i_rst_n = 0; #1;
    chk("rstw_abort", {o_mem_req, o_mem_we, o_busy, o_done, o_err}, 5'b00000);
    i_ctl_to_ir = 1; #1; chk("rstw_buf", o_mbr_ir, 16'h0000);
    tick(); i_rst_n = 1; i_mem_ack = 1; i_mem_rdata = 16'hDEAD; #1;
    tick(); i_mem_ack = 0; #1;
    chk("rstw_late_ack", {o_mem_req, o_busy, o_done, o_err}, 4'b0000);
    chk("rstw_buf_after", o_mbr_ir, 16'h0000);
    clr_in();

    // Random traffic against the transaction model
    m_buf = '0; m_mode = 0; m_waits = 0; m_done = 0; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] exp_ir, exp_br;
      logic [7:0]  exp_pc;
      i_ctl_rd     = ($urandom_range(0, 5) == 0);
      i_ctl_wr     = ($urandom_range(0, 5) == 0);
      i_ctl_acc_in = ($urandom_range(0, 3) == 0);
      i_ctl_pc_in  = ($urandom_range(0, 3) == 0);
      i_pc_mbr     = i_ctl_pc_in ? 8'($urandom_range(1, 255)) : 8'h00;
      i_acc_mbr    = 16'($urandom);
      i_mem_ack    = ($urandom_range(0, 7) == 0);
      i_mem_rdata  = 16'($urandom);
      i_ctl_to_pc  = $urandom_range(0, 1);
      i_ctl_to_ir  = $urandom_range(0, 1);
      i_ctl_to_br  = $urandom_range(0, 1);
      #1;
      exp_pc = i_ctl_to_pc ? m_buf[7:0] : 8'h00;
      exp_ir = i_ctl_to_ir ? m_buf : 16'h0000;
      exp_br = i_ctl_to_br ? m_buf : 16'h0000;
      chk("rnd_ctl", {o_mem_req, o_mem_we, o_busy, o_done, o_err},
          {m_mode != 0, m_mode == 2, m_mode != 0, m_done, m_err});
      chk("rnd_gate", {o_mbr_pc, o_mbr_ir}, {exp_pc, exp_ir});
      chk("rnd_br_wdata", {o_mbr_br, o_mem_wdata}, {exp_br, m_buf});
      if (m_mode == 0) begin
        m_done = 0;
        if (i_ctl_acc_in)     m_buf = i_acc_mbr;
        else if (i_ctl_pc_in) m_buf = {8'h00, i_pc_mbr};
        if (i_ctl_rd)      begin m_mode = 1; m_waits = 0; m_err = 0; end
        else if (i_ctl_wr) begin m_mode = 2; m_waits = 0; m_err = 0; end
      end else if (i_mem_ack) begin
        if (m_mode == 1) m_buf = i_mem_rdata;
        m_done = 1;
        m_mode = 0;
      end else begin
        m_done = 0;
        m_waits++;
        if (m_waits == 15) begin m_mode = 0; m_err = 1; end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
